id_stage: RTL

- Instruction-decode stage of the 5-stage MIPS pipeline.
- Receiving end of the IF/ID interface: consumes IFID_pc/IFID_ir from the IF stage.
- Reads the 32x32 register file (written back from WB) and sign-extends the immediate.
- Generates control, detects load-use hazards, and registers everything into the ID/EX pipeline register.

---
 rtl/id_stage.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : Instruction-decode stage of the 5-stage MIPS pipeline.
//                Consumes IF/ID, reads the register file written back
//                from WB, sign-extends the immediate, decodes control,
//                detects load-use hazards and registers everything into
//                the ID/EX pipeline register.
//  Options     : ID_REGFILE_BYPASS_EN - when defined, a WB write to the
//                register being read in the same cycle is returned by the
//                read (write-before-read). When undefined the read returns
//                the old contents and the new value appears next cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic [DATA_W-1:0] IFID_pc_i,
    input  logic [31:0]       IFID_ir_i,
    input  logic              WB_reg_write_i,
    input  logic [REG_AW-1:0] WB_write_reg_i,
    input  logic [DATA_W-1:0] WB_write_data_i,
    input  logic              MEM_ctrl_pc_src_i,
    output logic              ID_stall_o,
    output logic [DATA_W-1:0] IDEX_pc_o,
    output logic [DATA_W-1:0] IDEX_rs_data_o,
    output logic [DATA_W-1:0] IDEX_rt_data_o,
    output logic [DATA_W-1:0] IDEX_imm_o,
    output logic [REG_AW-1:0] IDEX_rs_o,
    output logic [REG_AW-1:0] IDEX_rt_o,
    output logic [REG_AW-1:0] IDEX_rd_o,
    output logic              IDEX_ctrl_reg_dst_o,
    output logic              IDEX_ctrl_alu_src_o,
    output logic              IDEX_ctrl_mem_to_reg_o,
    output logic              IDEX_ctrl_reg_write_o,
    output logic              IDEX_ctrl_mem_read_o,
    output logic              IDEX_ctrl_mem_write_o,
    output logic              IDEX_ctrl_branch_o,
    output logic [1:0]        IDEX_ctrl_alu_op_o
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int c_num_regs = 1 << REG_AW;

    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;

    localparam logic [1:0] c_alu_add   = 2'b00;
    localparam logic [1:0] c_alu_sub   = 2'b01;
    localparam logic [1:0] c_alu_funct = 2'b10;

    // ------------------------------------------------------------------
    // Instruction fields
    // ------------------------------------------------------------------
    logic [5:0]        w_opcode;
    logic [REG_AW-1:0] w_rs_addr;
    logic [REG_AW-1:0] w_rt_addr;
    logic [REG_AW-1:0] w_rd_addr;
    logic [15:0]       w_imm16;
    logic [DATA_W-1:0] w_imm_ext;

    assign w_opcode  = IFID_ir_i[31:26];
    assign w_rs_addr = IFID_ir_i[25:21];
    assign w_rt_addr = IFID_ir_i[20:16];
    assign w_rd_addr = IFID_ir_i[15:11];
    assign w_imm16   = IFID_ir_i[15:0];
    assign w_imm_ext = {{(DATA_W-16){w_imm16[15]}}, w_imm16};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_regs [c_num_regs];
    logic              w_wb_we;
    logic              w_rs_fwd;
    logic              w_rt_fwd;
    logic [DATA_W-1:0] w_rs_data;
    logic [DATA_W-1:0] w_rt_data;

    // Register 0 is hard-wired to zero, so writes to it are dropped.
    assign w_wb_we = WB_reg_write_i && (WB_write_reg_i != '0);

    // Register file storage: cleared by reset, written from WB.
    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            for (int i = 0; i < c_num_regs; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_wb_we) begin
            r_regs[WB_write_reg_i] <= WB_write_data_i;
        end
    end

`ifdef ID_REGFILE_BYPASS_EN
    // Same-cycle WB write is forwarded straight to the read ports.
    assign w_rs_fwd = w_wb_we && (WB_write_reg_i == w_rs_addr);
    assign w_rt_fwd = w_wb_we && (WB_write_reg_i == w_rt_addr);
`else
    // Reads see the register contents before this cycle's WB write.
    assign w_rs_fwd = 1'b0;
    assign w_rt_fwd = 1'b0;
`endif

    // Asynchronous read ports; register 0 always reads as zero.
    always_comb begin
        w_rs_data = '0;
        w_rt_data = '0;
        if (w_rs_addr != '0) begin
            w_rs_data = w_rs_fwd ? WB_write_data_i : r_regs[w_rs_addr];
        end
        if (w_rt_addr != '0) begin
            w_rt_data = w_rt_fwd ? WB_write_data_i : r_regs[w_rt_addr];
        end
    end

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic       w_reg_dst;
    logic       w_alu_src;
    logic       w_mem_to_reg;
    logic       w_reg_write;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_branch;
    logic [1:0] w_alu_op;

    // Main decoder; unrecognised opcodes behave as a NOP.
    always_comb begin
        w_reg_dst    = 1'b0;
        w_alu_src    = 1'b0;
        w_mem_to_reg = 1'b0;
        w_reg_write  = 1'b0;
        w_mem_read   = 1'b0;
        w_mem_write  = 1'b0;
        w_branch     = 1'b0;
        w_alu_op     = c_alu_add;
        case (w_opcode)
            c_op_rtype: begin
                w_reg_dst   = 1'b1;
                w_reg_write = 1'b1;
                w_alu_op    = c_alu_funct;
            end
            c_op_lw: begin
                w_alu_src    = 1'b1;
                w_mem_to_reg = 1'b1;
                w_reg_write  = 1'b1;
                w_mem_read   = 1'b1;
            end
            c_op_sw: begin
                w_alu_src   = 1'b1;
                w_mem_write = 1'b1;
            end
            c_op_beq: begin
                w_branch = 1'b1;
                w_alu_op = c_alu_sub;
            end
            c_op_addi: begin
                w_alu_src   = 1'b1;
                w_reg_write = 1'b1;
            end
            default: begin
                w_alu_op = c_alu_add;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load-use hazard detection
    // ------------------------------------------------------------------
    logic r_idex_mem_read;
    logic [REG_AW-1:0] r_idex_rt;
    logic w_stall;
    logic w_kill_ctrl;

    // A load in EX whose destination feeds this instruction must stall one cycle.
    assign w_stall = r_idex_mem_read && (r_idex_rt != '0) &&
                     ((r_idex_rt == w_rs_addr) || (r_idex_rt == w_rt_addr));

    // Flush and stall both turn the ID/EX entry into a bubble.
    assign w_kill_ctrl = MEM_ctrl_pc_src_i || w_stall;

    assign ID_stall_o = w_stall;

    // ------------------------------------------------------------------
    // ID/EX pipeline register
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_idex_pc;
    logic [DATA_W-1:0] r_idex_rs_data;
    logic [DATA_W-1:0] r_idex_rt_data;
    logic [DATA_W-1:0] r_idex_imm;
    logic [REG_AW-1:0] r_idex_rs;
    logic [REG_AW-1:0] r_idex_rd;

    // Data fields always load; they are harmless inside a bubble.
    always_ff @(posedge clk_i) begin
        if (!n_rst_i) begin
            r_idex_pc      <= '0;
            r_idex_rs_data <= '0;
            r_idex_rt_data <= '0;
            r_idex_imm     <= '0;
            r_idex_rs      <= '0;
            r_idex_rt      <= '0;
            r_idex_rd      <= '0;
        end else begin
            r_idex_pc      <= IFID_pc_i;
            r_idex_rs_data <= w_rs_data;
            r_idex_rt_data <= w_rt_data;
            r_idex_imm     <= w_imm_ext;
            r_idex_rs      <= w_rs_addr;
            r_idex_rt      <= w_rt_addr;
            r_idex_rd      <= w_rd_addr;
        end
    end

    logic       r_idex_reg_dst;
    logic       r_idex_alu_src;
    logic       r_idex_mem_to_reg;
    logic       r_idex_reg_write;
    logic       r_idex_mem_write;
    logic       r_idex_branch;
    logic [1:0] r_idex_alu_op;

    // Control fields: zeroed on reset, flush or stall, otherwise decoded.
    always_ff @(posedge clk_i) begin
        if (!n_rst_i || w_kill_ctrl) begin
            r_idex_reg_dst    <= 1'b0;
            r_idex_alu_src    <= 1'b0;
            r_idex_mem_to_reg <= 1'b0;
            r_idex_reg_write  <= 1'b0;
            r_idex_mem_read   <= 1'b0;
            r_idex_mem_write  <= 1'b0;
            r_idex_branch     <= 1'b0;
            r_idex_alu_op     <= 2'b00;
        end else begin
            r_idex_reg_dst    <= w_reg_dst;
            r_idex_alu_src    <= w_alu_src;
            r_idex_mem_to_reg <= w_mem_to_reg;
            r_idex_reg_write  <= w_reg_write;
            r_idex_mem_read   <= w_mem_read;
            r_idex_mem_write  <= w_mem_write;
            r_idex_branch     <= w_branch;
            r_idex_alu_op     <= w_alu_op;
        end
    end

    assign IDEX_pc_o              = r_idex_pc;
    assign IDEX_rs_data_o         = r_idex_rs_data;
    assign IDEX_rt_data_o         = r_idex_rt_data;
    assign IDEX_imm_o             = r_idex_imm;
    assign IDEX_rs_o              = r_idex_rs;
    assign IDEX_rt_o              = r_idex_rt;
    assign IDEX_rd_o              = r_idex_rd;
    assign IDEX_ctrl_reg_dst_o    = r_idex_reg_dst;
    assign IDEX_ctrl_alu_src_o    = r_idex_alu_src;
    assign IDEX_ctrl_mem_to_reg_o = r_idex_mem_to_reg;
    assign IDEX_ctrl_reg_write_o  = r_idex_reg_write;
    assign IDEX_ctrl_mem_read_o   = r_idex_mem_read;
    assign IDEX_ctrl_mem_write_o  = r_idex_mem_write;
    assign IDEX_ctrl_branch_o     = r_idex_branch;
    assign IDEX_ctrl_alu_op_o     = r_idex_alu_op;

endmodule
`default_nettype wire
